ifid_hazard_ctrl: RTL

Pipeline hazard and sequencing controller for the IF/ID register and the PC. It generates the IF/ID stall (IFIDWrite, 1 = hold) and flush, the PC hold, and the ID/EX bubble. It also sequences EX-stage holds for a multi-cycle EX op (mul/div) and waits on a not-ready instruction memory, with a timeout watchdog. It sits beside the IF/ID and ID/EX registers in the 5-stage core.

---
 rtl/ifid_hazard_ctrl.sv | 102 ++++++++++
 1 files changed

// File: rtl/ifid_hazard_ctrl.sv
// ifid_hazard_ctrl: IF/ID stall/flush, PC hold, ID/EX bubble and EX hold sequencing with imem timeout
module ifid_hazard_ctrl #(
  parameter int REG_ADDR_W   = 5,
  parameter int MC_LAT       = 4,
  parameter int IMEM_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  ex_valid,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_mc_start,
  input  logic                  branch_taken,
  input  logic                  imem_ready,
  output logic                  IFIDWrite,
  output logic                  ifid_flush,
  output logic                  pc_hold,
  output logic                  idex_bubble,
  output logic                  ex_hold,
  output logic                  imem_err,
  output logic [1:0]            state_o
);
  localparam int TW = $clog2(IMEM_TIMEOUT + 1);
  typedef enum logic [1:0] {RUN = 2'd0, MCWAIT = 2'd1, IWAIT = 2'd2} state_t;
  state_t state_q, state_d;
  logic [7:0] mc_cnt_q, mc_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic imem_err_q, imem_err_d;
  logic load_use, br, mc, stall, flush, hold, bubble, exh;
  assign load_use = ex_valid & ex_mem_read & (ex_rd != '0) &
                    ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
  assign br = ex_valid & branch_taken;
  assign mc = ex_valid & ex_mc_start;
  always_comb begin
    state_d  = state_q;
    mc_cnt_d = mc_cnt_q;
    to_cnt_d = to_cnt_q;
    stall    = 1'b0;
    flush    = 1'b0;
    hold     = 1'b0;
    bubble   = 1'b0;
    exh      = 1'b0;
    if (state_q == RUN) begin
      if (br) begin
        flush  = 1'b1;
        bubble = 1'b1;
      end else if (mc) begin
        stall    = 1'b1;
        hold     = 1'b1;
        exh      = 1'b1;
        state_d  = (MC_LAT > 2) ? MCWAIT : RUN;
        mc_cnt_d = 8'(MC_LAT - 2);
      end else if (load_use) begin
        stall  = 1'b1;
        hold   = 1'b1;
        bubble = 1'b1;
      end else if (!imem_ready) begin
        flush    = 1'b1;
        hold     = 1'b1;
        state_d  = IWAIT;
        to_cnt_d = TW'(1);
      end
    end else if (state_q == MCWAIT) begin
      stall    = 1'b1;
      hold     = 1'b1;
      exh      = 1'b1;
      mc_cnt_d = mc_cnt_q - 8'd1;
      state_d  = (mc_cnt_q <= 8'd1) ? RUN : MCWAIT;
    end else begin
      flush    = !imem_ready | br;
      hold     = !imem_ready & !br;
      bubble   = br;
      state_d  = imem_ready ? RUN : IWAIT;
      to_cnt_d = imem_ready ? '0 : (to_cnt_q == TW'(IMEM_TIMEOUT)) ? to_cnt_q : to_cnt_q + TW'(1);
    end
    imem_err_d = imem_err_q | (to_cnt_d == TW'(IMEM_TIMEOUT));
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      mc_cnt_q   <= '0;
      to_cnt_q   <= '0;
      imem_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mc_cnt_q   <= mc_cnt_d;
      to_cnt_q   <= to_cnt_d;
      imem_err_q <= imem_err_d;
    end
  end
  assign IFIDWrite   = stall & ~reset;
  assign ifid_flush  = flush & ~reset;
  assign pc_hold     = hold & ~reset;
  assign idex_bubble = bubble & ~reset;
  assign ex_hold     = exh & ~reset;
  assign imem_err    = imem_err_q & ~reset;
  assign state_o     = state_q;
endmodule
